// File: rtl/datactrl_pkg.sv
// datactrl_pkg: shared width encodings, FSM states and helpers for data_ctrl.
package datactrl_pkg;

    localparam logic [2:0]  W_BYTE      = 3'b001;
    localparam logic [2:0]  W_HALF      = 3'b010;
    localparam logic [2:0]  W_WORD      = 3'b100;
    localparam logic [31:0] IO_ADDR_DEF = 32'h0003_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STORE,
        S_LOAD_ADDR,
        S_LOAD_DATA
    } state_t;

    // Unknown encodings fall back to a single byte.
    function automatic logic [2:0] width_bytes(input logic [2:0] w);
        case (w)
            W_HALF:  return 3'd2;
            W_WORD:  return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/data_ctrl_if.sv
// data_ctrl_if: byte-wide RAM/IO port; data_ctrl is the master, the memory the slave.
interface data_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;

    modport master (input mem_din, output mem_dout, output mem_a, output mem_wr);
    modport slave  (output mem_din, input mem_dout, input mem_a, input mem_wr);
endinterface

// File: rtl/data_ctrl_ext.sv
// data_ctrl_ext: sign- or zero-extends the low 1/2/4 bytes of a load word to DATA_W.
module data_ctrl_ext #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] raw_in,
    input  logic [2:0]        nbytes_in,
    input  logic              signed_in,
    output logic [DATA_W-1:0] ext_out
);

    always_comb begin
        ext_out = raw_in;
        case (nbytes_in)
            3'd1:    ext_out = {{(DATA_W-8){signed_in & raw_in[7]}}, raw_in[7:0]};
            3'd2:    ext_out = {{(DATA_W-16){signed_in & raw_in[15]}}, raw_in[15:0]};
            default: ext_out = raw_in;
        endcase
    end

endmodule

// File: rtl/data_ctrl.sv
// data_ctrl: serialises committed ROB stores and load-buffer loads onto a byte RAM/IO port.
// Optional DATACTRL_IOBUF_STALL_EN: IO-window store bytes wait while io_buffer_full_in is high.
module data_ctrl
    import datactrl_pkg::*;
#(
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 32,
    parameter logic [31:0] IO_ADDR = IO_ADDR_DEF
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              rob_rst_in,
    input  logic              rob_datactrl_en_in,
    input  logic [ADDR_W-1:0] rob_datactrl_addr_in,
    input  logic [2:0]        rob_datactrl_width_in,
    input  logic [DATA_W-1:0] rob_datactrl_data_in,
    output logic              datactrl_rob_en_out,
    input  logic              lbuffer_datactrl_en_in,
    input  logic [ADDR_W-1:0] lbuffer_datactrl_addr_in,
    input  logic [2:0]        lbuffer_datactrl_width_in,
    input  logic              lbuffer_datactrl_signed_in,
    output logic              datactrl_lbuffer_en_out,
    output logic [DATA_W-1:0] datactrl_lbuffer_data_out,
`ifdef DATACTRL_IOBUF_STALL_EN
    input  logic              io_buffer_full_in,
`endif
    data_ctrl_if.master       mem
);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d, last_q, last_d, cap_idx;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d, pend_addr_q, pend_addr_d, src_addr;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d, st_done_q, st_done_d, ld_done_q, ld_done_d;
    logic              ld_sgn_q, ld_sgn_d, pend_vld_q, pend_vld_d;
    logic [2:0]        pend_w_q, pend_w_d, src_w, ld_nbytes;
    logic [DATA_W-1:0] pend_data_q, pend_data_d, src_data, st_data_q, st_data_d;
    logic [DATA_W-1:0] ld_buf_q, ld_buf_d, ld_data_q, ld_data_d, ld_word, ld_ext;
    logic              src_wait, nxt_wait, stall;

    // A pending store takes priority over a freshly pulsed one; both never coexist.
    assign src_addr = pend_vld_q ? pend_addr_q : rob_datactrl_addr_in;
    assign src_w    = pend_vld_q ? pend_w_q    : rob_datactrl_width_in;
    assign src_data = pend_vld_q ? pend_data_q : rob_datactrl_data_in;

`ifdef DATACTRL_IOBUF_STALL_EN
    function automatic logic io_hit(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: 15] == IO_ADDR[31:17];
    endfunction
    assign src_wait = io_hit(src_addr);
    assign nxt_wait = io_hit(mem_a_q + ADDR_W'(1));
    assign stall    = io_buffer_full_in;
`else
    logic unused_io;
    assign unused_io = ^IO_ADDR;
    assign src_wait  = 1'b0;
    assign nxt_wait  = 1'b0;
    assign stall     = 1'b0;
`endif

    // The byte arriving on mem_din belongs to the address issued one cycle earlier.
    always_comb begin
        cap_idx = (state_q == S_LOAD_DATA) ? last_q : cnt_q - 2'd1;
        ld_word = ld_buf_q;
        ld_word[8*cap_idx +: 8] = mem.mem_din;
    end

    assign ld_nbytes = {1'b0, last_q} + 3'd1;

    data_ctrl_ext #(.DATA_W(DATA_W)) u_ext (
        .raw_in    (ld_word),
        .nbytes_in (ld_nbytes),
        .signed_in (ld_sgn_q),
        .ext_out   (ld_ext)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = 1'b0;
        st_done_d   = 1'b0;
        ld_done_d   = 1'b0;
        ld_data_d   = ld_data_q;
        ld_sgn_d    = ld_sgn_q;
        st_data_d   = st_data_q;
        ld_buf_d    = ld_buf_q;
        pend_vld_d  = pend_vld_q | rob_datactrl_en_in;
        pend_addr_d = rob_datactrl_en_in ? rob_datactrl_addr_in  : pend_addr_q;
        pend_w_d    = rob_datactrl_en_in ? rob_datactrl_width_in : pend_w_q;
        pend_data_d = rob_datactrl_en_in ? rob_datactrl_data_in  : pend_data_q;
        case (state_q)
            S_IDLE: begin
                if (pend_vld_q || rob_datactrl_en_in) begin
                    state_d    = S_STORE;
                    pend_vld_d = 1'b0;
                    cnt_d      = 2'd0;
                    last_d     = 2'(width_bytes(src_w) - 3'd1);
                    mem_a_d    = src_addr;
                    mem_dout_d = src_data[7:0];
                    st_data_d  = src_data;
                    mem_wr_d   = !src_wait;
                // While the done pulse is up, the held request is the one just served.
                end else if (lbuffer_datactrl_en_in && !rob_rst_in && !ld_done_q) begin
                    state_d  = S_LOAD_ADDR;
                    cnt_d    = 2'd0;
                    last_d   = 2'(width_bytes(lbuffer_datactrl_width_in) - 3'd1);
                    mem_a_d  = lbuffer_datactrl_addr_in;
                    ld_sgn_d = lbuffer_datactrl_signed_in;
                end
            end
            S_STORE: begin
                if (!mem_wr_q) begin
                    mem_wr_d = !stall;
                end else if (cnt_q == last_q) begin
                    state_d   = S_IDLE;
                    st_done_d = 1'b1;
                end else begin
                    cnt_d      = cnt_q + 2'd1;
                    mem_a_d    = mem_a_q + ADDR_W'(1);
                    mem_dout_d = st_data_q[8*cnt_d +: 8];
                    mem_wr_d   = !nxt_wait;
                end
            end
            S_LOAD_ADDR: begin
                ld_buf_d = ld_word;
                if (rob_rst_in) begin
                    state_d = S_IDLE;
                end else if (cnt_q == last_q) begin
                    state_d = S_LOAD_DATA;
                end else begin
                    cnt_d   = cnt_q + 2'd1;
                    mem_a_d = mem_a_q + ADDR_W'(1);
                end
            end
            S_LOAD_DATA: begin
                ld_buf_d = ld_word;
                state_d  = S_IDLE;
                if (!rob_rst_in) begin
                    ld_done_d = 1'b1;
                    ld_data_d = ld_ext;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            last_q     <= 2'd0;
            mem_a_q    <= '0;
            mem_dout_q <= 8'h00;
            mem_wr_q   <= 1'b0;
            st_done_q  <= 1'b0;
            ld_done_q  <= 1'b0;
            ld_data_q  <= '0;
            ld_sgn_q   <= 1'b0;
            pend_vld_q <= 1'b0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            st_done_q  <= st_done_d;
            ld_done_q  <= ld_done_d;
            ld_data_q  <= ld_data_d;
            ld_sgn_q   <= ld_sgn_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            pend_addr_q <= pend_addr_d;
            pend_w_q    <= pend_w_d;
            pend_data_q <= pend_data_d;
            st_data_q   <= st_data_d;
            ld_buf_q    <= ld_buf_d;
        end
    end

    assign mem.mem_a                 = mem_a_q;
    assign mem.mem_dout              = mem_dout_q;
    assign mem.mem_wr                = mem_wr_q & rdy_in;
    assign datactrl_rob_en_out       = st_done_q & rdy_in;
    assign datactrl_lbuffer_en_out   = ld_done_q & rdy_in;
    assign datactrl_lbuffer_data_out = ld_data_q;

endmodule

// File: tb/tb_data_ctrl.sv
// tb_data_ctrl: directed-vector bench for data_ctrl with a small fixed-content RAM model.
module tb_data_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rdy = 1'b1;
    logic        rob_rst = 1'b0;
    logic        rob_en = 1'b0;
    logic [31:0] rob_addr = '0;
    logic [2:0]  rob_w = 3'b001;
    logic [31:0] rob_data = '0;
    logic        rob_done;
    logic        lb_en = 1'b0;
    logic [31:0] lb_addr = '0;
    logic [2:0]  lb_w = 3'b001;
    logic        lb_sgn = 1'b0;
    logic        ld_done;
    logic [31:0] ld_data;
`ifdef DATACTRL_IOBUF_STALL_EN
    logic        io_full = 1'b0;
`endif
    int n_chk = 0;
    int n_fail = 0;

    data_ctrl_if #(.ADDR_W(32)) mem_if ();

    data_ctrl dut (
        .clk_in                     (clk),
        .rst_n_in                   (rst_n),
        .rdy_in                     (rdy),
        .rob_rst_in                 (rob_rst),
        .rob_datactrl_en_in         (rob_en),
        .rob_datactrl_addr_in       (rob_addr),
        .rob_datactrl_width_in      (rob_w),
        .rob_datactrl_data_in       (rob_data),
        .datactrl_rob_en_out        (rob_done),
        .lbuffer_datactrl_en_in     (lb_en),
        .lbuffer_datactrl_addr_in   (lb_addr),
        .lbuffer_datactrl_width_in  (lb_w),
        .lbuffer_datactrl_signed_in (lb_sgn),
        .datactrl_lbuffer_en_out    (ld_done),
        .datactrl_lbuffer_data_out  (ld_data),
`ifdef DATACTRL_IOBUF_STALL_EN
        .io_buffer_full_in          (io_full),
`endif
        .mem                        (mem_if)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        case (a)
            32'h200: return 8'h80;
            32'h210: return 8'h11;
            32'h211: return 8'h22;
            32'h212: return 8'h33;
            32'h213: return 8'hF4;
            default: return 8'h00;
        endcase
    endfunction

    // Read data appears the cycle after the address.
    always @(posedge clk) mem_if.mem_din <= rd_byte(mem_if.mem_a);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic start_store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] w);
        rob_en = 1'b1; rob_addr = addr; rob_data = data; rob_w = w;
        step();
        rob_en = 1'b0;
    endtask

    task automatic expect_store(input string tag, input logic [31:0] addr, input logic [31:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_wr"}, 32'(mem_if.mem_wr), 32'd1);
            check({tag, "_a"}, mem_if.mem_a, addr + 32'(i));
            check({tag, "_d"}, 32'(mem_if.mem_dout), 32'(data[8*i +: 8]));
            step();
        end
        check({tag, "_done"}, 32'(rob_done), 32'd1);
        check({tag, "_wr0"}, 32'(mem_if.mem_wr), 32'd0);
        step();
        check({tag, "_done0"}, 32'(rob_done), 32'd0);
    endtask

    task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] w,
                            input logic sgn, input int n, input logic [31:0] exp);
        lb_en = 1'b1; lb_addr = addr; lb_w = w; lb_sgn = sgn;
        step();
        check({tag, "_a"}, mem_if.mem_a, addr);
        check({tag, "_wr"}, 32'(mem_if.mem_wr), 32'd0);
        for (int i = 1; i <= n; i++) step();
        check({tag, "_early"}, 32'(ld_done), 32'd0);
        step();
        check({tag, "_done"}, 32'(ld_done), 32'd1);
        check({tag, "_data"}, ld_data, exp);
        lb_en = 1'b0;
        step();
        check({tag, "_done0"}, 32'(ld_done), 32'd0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) step();
        check("rst_wr", 32'(mem_if.mem_wr), 32'd0);
        check("rst_a", mem_if.mem_a, 32'd0);
        check("rst_dout", 32'(mem_if.mem_dout), 32'd0);
        check("rst_robdone", 32'(rob_done), 32'd0);
        check("rst_lddone", 32'(ld_done), 32'd0);
        rst_n = 1'b1;
        step();

        start_store(32'h100, 32'hDEADBEEF, 3'b100);
        expect_store("sw", 32'h100, 32'hDEADBEEF, 4);

        run_load("lb", 32'h200, 3'b001, 1'b1, 1, 32'hFFFF_FF80);
        run_load("lbu", 32'h200, 3'b001, 1'b0, 1, 32'h0000_0080);
        run_load("lh", 32'h212, 3'b010, 1'b1, 2, 32'hFFFF_F433);

        // store and load requested together: store first, load on the store-done cycle
        lb_en = 1'b1; lb_addr = 32'h210; lb_w = 3'b100; lb_sgn = 1'b0;
        start_store(32'h300, 32'h0000_1234, 3'b010);
        check("mix_a0", mem_if.mem_a, 32'h300);
        check("mix_d0", 32'(mem_if.mem_dout), 32'h34);
        step();
        check("mix_d1", 32'(mem_if.mem_dout), 32'h12);
        step();
        check("mix_sdone", 32'(rob_done), 32'd1);
        step();
        check("mix_la", mem_if.mem_a, 32'h210);
        check("mix_lwr", 32'(mem_if.mem_wr), 32'd0);
        repeat (4) step();
        check("mix_early", 32'(ld_done), 32'd0);
        step();
        check("mix_ldone", 32'(ld_done), 32'd1);
        check("mix_ldata", ld_data, 32'hF433_2211);
        lb_en = 1'b0;
        step();

        // flush during a word load; a store latched meanwhile still runs
        lb_en = 1'b1; lb_addr = 32'h210; lb_w = 3'b100; lb_sgn = 1'b0;
        step();
        check("fl_a", mem_if.mem_a, 32'h210);
        rob_en = 1'b1; rob_addr = 32'h400; rob_data = 32'h5A; rob_w = 3'b001;
        step();
        rob_en = 1'b0; rob_rst = 1'b1; lb_en = 1'b0;
        step();
        rob_rst = 1'b0;
        check("fl_ld3", 32'(ld_done), 32'd0);
        check("fl_wr3", 32'(mem_if.mem_wr), 32'd0);
        step();
        check("fl_swr", 32'(mem_if.mem_wr), 32'd1);
        check("fl_sa", mem_if.mem_a, 32'h400);
        check("fl_sd", 32'(mem_if.mem_dout), 32'h5A);
        step();
        check("fl_sdone", 32'(rob_done), 32'd1);
        check("fl_ld5", 32'(ld_done), 32'd0);
        step();
        check("fl_ld6", 32'(ld_done), 32'd0);

        // rdy_in low freezes the store and masks the write strobe
        start_store(32'h600, 32'h99, 3'b001);
        check("rdy_wr1", 32'(mem_if.mem_wr), 32'd1);
        rdy = 1'b0;
        #1 check("rdy_wr0", 32'(mem_if.mem_wr), 32'd0);
        step();
        check("rdy_hold_a", mem_if.mem_a, 32'h600);
        check("rdy_nodone", 32'(rob_done), 32'd0);
        rdy = 1'b1;
        #1 check("rdy_wr_back", 32'(mem_if.mem_wr), 32'd1);
        step();
        check("rdy_done", 32'(rob_done), 32'd1);
        step();

        start_store(32'h700, 32'h0000_AABB, 3'b011);
        expect_store("wbad", 32'h700, 32'h0000_AABB, 1);
        start_store(32'hFFFF_FFFF, 32'h0000_C3D4, 3'b010);
        expect_store("wrap", 32'hFFFF_FFFF, 32'h0000_C3D4, 2);

`ifdef DATACTRL_IOBUF_STALL_EN
        io_full = 1'b1;
        start_store(32'h3_0000, 32'h77, 3'b001);
        check("io_hold1", 32'(mem_if.mem_wr), 32'd0);
        step();
        check("io_hold2", 32'(mem_if.mem_wr), 32'd0);
        step();
        check("io_hold3", 32'(mem_if.mem_wr), 32'd0);
        io_full = 1'b0;
        step();
        expect_store("io", 32'h3_0000, 32'h77, 1);
`else
        start_store(32'h3_0000, 32'h77, 3'b001);
        expect_store("io", 32'h3_0000, 32'h77, 1);
`endif

        // asynchronous reset in the middle of a word store
        start_store(32'h500, 32'h0102_0304, 3'b100);
        step();
        check("ar_wr_pre", 32'(mem_if.mem_wr), 32'd1);
        rst_n = 1'b0;
        #1;
        check("ar_wr", 32'(mem_if.mem_wr), 32'd0);
        check("ar_a", mem_if.mem_a, 32'd0);
        check("ar_dout", 32'(mem_if.mem_dout), 32'd0);
        check("ar_ldata", ld_data, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("ar_idle_wr", 32'(mem_if.mem_wr), 32'd0);
        start_store(32'h100, 32'hDEADBEEF, 3'b100);
        expect_store("ar_sw", 32'h100, 32'hDEADBEEF, 4);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1);
    end

endmodule
